// File: rtl/depth_pkg.sv
// Shared constants, FSM encoding and lane-slice macro for the depthwise weight loader.
// Optional checksum output is enabled with DEPTH_WEIGHTS_CHECKSUM_EN.
`ifndef DEPTH_LANE
`define DEPTH_LANE(k, w) (k)*(w) +: (w)
`endif

package depth_pkg;
  localparam int DATA_WIDTH = 14;
  localparam int TAPS       = 25;
  localparam int HEIGHT     = 2480;
  localparam int ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FIN     = 2'd3
  } state_t;
endpackage

// File: rtl/depth_tap_assembler.sv
// Row register of TAPS lanes plus the tap counter; flags the last tap of a row.
// Lanes are overwritten in place, so the row doubles as the memory data bus.
module depth_tap_assembler
  import depth_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int N  = TAPS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic [DW-1:0] din,
  output logic [N*DW-1:0] row,
  output logic          last
);
  localparam int CW = $clog2(N);

  logic [CW-1:0] tap_cnt;

  assign last = load && (tap_cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row     <= '0;
      tap_cnt <= '0;
    end else if (clear) begin
      tap_cnt <= '0;
    end else if (load) begin
      row[`DEPTH_LANE(tap_cnt, DW)] <= din;
      tap_cnt <= last ? '0 : tap_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/depth_weights_loader.sv
// Packs serial kernel taps into rows and writes them to the depthwise weight memory.
// Define DEPTH_WEIGHTS_CHECKSUM_EN to add the 16-bit tap checksum output.
module depth_weights_loader
  import depth_pkg::*;
#(
  parameter int DW  = DATA_WIDTH,
  parameter int NT  = TAPS,
  parameter int HT  = HEIGHT,
  parameter int AW  = ADDR_WIDTH
) (
`ifdef DEPTH_WEIGHTS_CHECKSUM_EN
  output logic [15:0]      checksum,
`endif
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW-1:0]    num_rows,
  input  logic             s_valid,
  input  logic [DW-1:0]    s_data,
  output logic             s_ready,
  output logic [NT*DW-1:0] mem_data,
  output logic [AW-1:0]    mem_index,
  output logic             mem_en,
  output logic             mem_wr,
  output logic             busy,
  output logic             done,
  output logic             err
);
  state_t state, nxt;

  logic [AW-1:0] base_q;
  logic [AW-1:0] rows_q;
  logic [AW-1:0] row_cnt;
  logic [AW:0]   end_row;
  logic          accept;
  logic          range_bad;
  logic          hs;
  logic          tap_last;
  logic          last_row;

  assign accept    = (state == IDLE) && start;
  assign end_row   = {1'b0, base_addr} + {1'b0, num_rows};
  assign range_bad = end_row > (AW+1)'(HT);
  assign hs        = s_valid && s_ready;
  assign last_row  = row_cnt == (rows_q - AW'(1));

  assign s_ready = state == COLLECT;
  assign mem_wr  = state == WRITE;
  assign mem_en  = state == WRITE;
  assign done    = state == FIN;
  assign busy    = state != IDLE;

  depth_tap_assembler #(
    .DW (DW),
    .N  (NT)
  ) u_asm (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .load  (hs),
    .din   (s_data),
    .row   (mem_data),
    .last  (tap_last)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (num_rows == '0)  nxt = FIN;
          else if (range_bad)  nxt = FIN;
          else                 nxt = COLLECT;
        end
      end
      COLLECT: if (tap_last) nxt = WRITE;
      WRITE:   nxt = last_row ? FIN : COLLECT;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      rows_q    <= '0;
      row_cnt   <= '0;
      err       <= 1'b0;
      mem_index <= '0;
    end else begin
      if (accept) begin
        base_q  <= base_addr;
        rows_q  <= num_rows;
        row_cnt <= '0;
        err     <= (num_rows != '0) && range_bad;
      end
      // Index is captured with the last tap so it holds after the write.
      if (tap_last) mem_index <= base_q + row_cnt;
      if (state == WRITE && !last_row) row_cnt <= row_cnt + AW'(1);
    end
  end

`ifdef DEPTH_WEIGHTS_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         checksum <= '0;
    else if (accept) checksum <= '0;
    else if (hs)     checksum <= checksum + 16'($signed(s_data));
  end
`endif
endmodule
